// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory requests over req/gnt/rvalid,
// aligns store and load data, and holds the MEM/WB register feeding writeback.
module mem_stage_lsu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_mem,
  input  logic [XLEN-1:0] alu_out_mem,
  input  logic [RD_W-1:0] rd_mem,
  input  logic [XLEN-1:0] rs2_data_mem,
  input  logic            mem_read_mem,
  input  logic            mem_write_mem,
  input  logic [2:0]      funct3_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_mem,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_exc
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            mem_exc_q, mem_exc_d;
  logic            ld_q, ld_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [RD_W-1:0] rd_q, rd_d;

  logic            mop, is_ld, f3_ok, misaligned, illegal;
  logic [1:0]      off;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] rdata_sh;
  logic [XLEN-1:0] ld_data;

  assign off   = alu_out_mem[1:0];
  assign mop   = valid_mem & (mem_read_mem | mem_write_mem);
  assign is_ld = mem_read_mem;

  always_comb begin
    if (is_ld) begin
      f3_ok = funct3_mem inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      f3_ok = funct3_mem inside {3'b000, 3'b001, 3'b010};
    end
    misaligned = ((funct3_mem[1:0] == 2'b01) && off[0]) ||
                 ((funct3_mem[1:0] == 2'b10) && (off != 2'b00));
    illegal    = !f3_ok || misaligned;
  end

  // Store lanes: data replicated so the byte/halfword lands on its lane.
  always_comb begin
    case (funct3_mem[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << off;
        lane_wdata = {4{rs2_data_mem[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << off;
        lane_wdata = {2{rs2_data_mem[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = rs2_data_mem;
      end
    endcase
  end

  assign rdata_sh = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_data = {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
      3'b001:  ld_data = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, rdata_sh[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mem_exc_d  = 1'b0;
    ld_d       = ld_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    stall_mem  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mop && !illegal) begin
          req_d     = 1'b1;
          we_d      = !is_ld;
          addr_d    = {alu_out_mem[XLEN-1:2], 2'b00};
          wdata_d   = lane_wdata;
          be_d      = lane_be;
          ld_d      = is_ld;
          f3_d      = funct3_mem;
          off_d     = off;
          rd_d      = rd_mem;
          state_d   = StReq;
          stall_mem = 1'b1;
        end else if (mop) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_mem;
          mem_exc_d  = 1'b1;
        end else if (valid_mem) begin
          wb_valid_d = 1'b1;
          wb_we_d    = (rd_mem != '0);
          wb_rd_d    = rd_mem;
          wb_data_d  = alu_out_mem;
        end
      end
      StReq: begin
        stall_mem = 1'b1;
        if (dmem_gnt) begin
          req_d = 1'b0;
          if (ld_q) begin
            state_d = StWaitR;
          end else begin
            state_d    = StIdle;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            stall_mem  = 1'b0;
          end
        end
      end
      StWaitR: begin
        stall_mem = 1'b1;
        if (dmem_rvalid) begin
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_we_d    = (rd_q != '0);
          wb_rd_d    = rd_q;
          wb_data_d  = ld_data;
          stall_mem  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mem_exc_q  <= 1'b0;
      ld_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mem_exc_q  <= mem_exc_d;
      ld_q       <= ld_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign mem_exc    = mem_exc_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: byte-array reference memory, randomized
// instruction stream, a random-latency memory responder and a decoupled monitor.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem, mem_read_mem, mem_write_mem;
  logic [31:0] alu_out_mem, rs2_data_mem;
  logic [4:0]  rd_mem;
  logic [2:0]  funct3_mem;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_mem, wb_valid, wb_we, mem_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .RD_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_mem    (valid_mem),
    .alu_out_mem  (alu_out_mem),
    .rd_mem       (rd_mem),
    .rs2_data_mem (rs2_data_mem),
    .mem_read_mem (mem_read_mem),
    .mem_write_mem(mem_write_mem),
    .funct3_mem   (funct3_mem),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .stall_mem    (stall_mem),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mem_exc      (mem_exc)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          we;
    bit          exc;
    bit          chk_rd;
    logic [4:0]  rd;
    bit          chk_data;
    logic [31:0] data;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] dmem_arr [16];  // responder-side memory, word addressed by addr[5:2]
  logic [7:0]  rb [64];        // reference memory, byte addressed by addr[5:0]
  bit          mem_auto = 1'b0;
  bit          mon_en = 1'b0;
  int          gnt_pct = 100;
  int          rv_max = 0;
  bit          m_pend = 1'b0;
  int          m_dly = 0;
  logic [3:0]  m_idx = '0;
  wb_t         mon_e;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: random gnt, load data returned 1..rv_max+1 cycles after gnt.
  always begin
    @(posedge clk);
    if (rst) begin
      m_pend = 1'b0;
    end else if (dmem_req && dmem_gnt) begin
      if (dmem_we) begin
        for (int l = 0; l < 4; l++)
          if (dmem_be[l]) dmem_arr[dmem_addr[5:2]][8*l +: 8] = dmem_wdata[8*l +: 8];
      end else begin
        m_pend = 1'b1;
        m_dly  = $urandom_range(0, rv_max);
        m_idx  = dmem_addr[5:2];
      end
    end
    #1;
    if (mem_auto) begin
      dmem_gnt = ($urandom_range(0, 99) < gnt_pct);
      if (m_pend && m_dly == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = dmem_arr[m_idx];
        m_pend      = 1'b0;
      end else begin
        if (m_pend) m_dly--;
        dmem_rvalid = !m_pend && ($urandom_range(0, 7) == 0);
        dmem_rdata  = $urandom;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (dmem_req) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h expected no request", dmem_addr);
        end else begin
          chk("req_we", dmem_we, req_q[0].we);
          chk("req_addr", dmem_addr, req_q[0].addr);
          if (req_q[0].we) begin
            chk("req_be", dmem_be, req_q[0].be);
            chk("req_wdata", dmem_wdata, req_q[0].wdata);
          end
          if (dmem_gnt) void'(req_q.pop_front());
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got wb_data %h expected no writeback", wb_data);
        end else begin
          mon_e = wb_q.pop_front();
          chk("wb_we", wb_we, mon_e.we);
          chk("wb_exc", mem_exc, mon_e.exc);
          if (mon_e.chk_rd) chk("wb_rd", wb_rd, mon_e.rd);
          if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
        end
      end else begin
        chk("exc_without_wb", mem_exc, 0);
      end
    end
  end

  // Present one instruction, push expectations, hold it until the unit accepts it.
  task automatic issue(bit v, bit rf, bit wf, logic [2:0] f3, logic [31:0] a, logic [4:0] rd,
                       logic [31:0] d);
    bit mop, ld, ill, granted, st_now, exp_st;
    int nb, off, idx, n;
    wb_t e;
    req_t r;
    logic [31:0] val;
    valid_mem = v; mem_read_mem = rf; mem_write_mem = wf;
    funct3_mem = f3; alu_out_mem = a; rd_mem = rd; rs2_data_mem = d;
    mop = v && (rf || wf);
    ld  = rf;
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    idx = int'(a[5:0]);
    ill = ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : !(f3 inside {3'd0, 3'd1, 3'd2});
    ill = ill || ((off % nb) != 0);
    e = '{we: 1'b0, exc: 1'b0, chk_rd: 1'b0, rd: rd, chk_data: 1'b0, data: '0};
    r = '{we: !ld, addr: {a[31:2], 2'b00}, be: '0, wdata: '0};
    if (v && !mop) begin
      e.we = (rd != 0); e.chk_rd = 1'b1; e.chk_data = 1'b1; e.data = a;
      wb_q.push_back(e);
    end else if (mop && ill) begin
      e.exc = 1'b1;
      wb_q.push_back(e);
    end else if (mop && ld) begin
      val = '0;
      for (int i = 0; i < nb; i++) val |= 32'(rb[idx+i]) << (8*i);
      if (!f3[2] && nb < 4 && val[8*nb-1]) val |= 32'hFFFF_FFFF << (8*nb);
      e.we = (rd != 0); e.chk_rd = 1'b1; e.chk_data = 1'b1; e.data = val;
      req_q.push_back(r);
      wb_q.push_back(e);
    end else if (mop) begin
      for (int i = 0; i < nb; i++) rb[idx+i] = d[8*i +: 8];
      for (int l = 0; l < 4; l++) begin
        r.be[l] = (l >= off) && (l < off + nb);
        r.wdata[8*l +: 8] = d[8*(l % nb) +: 8];
      end
      req_q.push_back(r);
      wb_q.push_back(e);
    end
    granted = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!mop || ill) exp_st = 1'b0;
      else if (!ld)    exp_st = !(dmem_req && dmem_gnt);
      else             exp_st = !(granted && dmem_rvalid);
      chk("stall", stall_mem, exp_st);
      if (dmem_req && dmem_gnt) granted = 1'b1;
      st_now = stall_mem;
      @(posedge clk);
      #1;
      if (!st_now) break;
      if (++n > 200) begin
        checks++;
        errors++;
        $display("FAIL timeout: got stall_mem stuck high expected release within 200 cycles");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  initial begin
    bit [2:0]    ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] x, a;
    logic [2:0]  f3;
    bit          rf, wf;
    int          k, nb;

    rst = 1'b1; valid_mem = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
    alu_out_mem = '0; rd_mem = '0; rs2_data_mem = '0; funct3_mem = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_exc", mem_exc, 0);
    chk("rst_stall", stall_mem, 0);

    // Reset while waiting for load data; the late rvalid must be dropped.
    @(posedge clk); #1;
    valid_mem = 1'b1; mem_read_mem = 1'b1; funct3_mem = 3'b010; alu_out_mem = 32'h100;
    rd_mem = 5'd4;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_req", dmem_req, 1);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("mid_wait_stall", stall_mem, 1);
    chk("mid_req_dropped", dmem_req, 0);
    rst = 1'b1; valid_mem = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_stall", stall_mem, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("mid_rst_wb_valid2", wb_valid, 0);
    chk("mid_rst_wb_data", wb_data, 0);
    chk("mid_rst_wb_we", wb_we, 0);

    for (int w = 0; w < 16; w++) begin
      x = (w == 0) ? 32'h12F3_4567 : $urandom;
      dmem_arr[w] = x;
      for (int b = 0; b < 4; b++) rb[4*w+b] = x[8*b +: 8];
    end
    mem_auto = 1'b1;
    mon_en = 1'b1;
    gnt_pct = 50;
    rv_max = 2;
    @(posedge clk); #1;

    issue(1, 0, 0, 3'd0, 32'h0000_1234, 5'd5, 32'h0);
    issue(1, 0, 0, 3'd0, 32'h0000_1234, 5'd0, 32'h0);
    issue(1, 1, 0, 3'b000, 32'h102, 5'd7, 32'h0);
    issue(1, 1, 0, 3'b100, 32'h102, 5'd8, 32'h0);
    issue(1, 1, 0, 3'b001, 32'h102, 5'd9, 32'h0);
    issue(1, 0, 1, 3'b000, 32'h103, 5'd1, 32'h0000_00A5);
    issue(1, 1, 0, 3'b010, 32'h101, 5'd2, 32'h0);
    issue(0, 0, 0, 3'd0, 32'h0, 5'd0, 32'h0);
    gnt_pct = 100;
    rv_max = 0;
    issue(1, 1, 0, 3'b010, 32'h200, 5'd3, 32'h0);
    issue(1, 0, 1, 3'b010, 32'h204, 5'd0, 32'h1122_3344);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        gnt_pct = 100;
        rv_max = 1;
      end else if (i == 0) begin
        gnt_pct = 60;
        rv_max = 3;
      end
      k = $urandom_range(0, 9);
      if (k == 0) begin
        rf = $urandom_range(0, 1);
        wf = $urandom_range(0, 1);
      end else if (k <= 2) begin
        rf = 1'b0;
        wf = 1'b0;
      end else begin
        rf = $urandom_range(0, 1);
        wf = !rf || ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 9) < 7) f3 = rf ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      a = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (nb == 2) a[0] = 1'b0;
        if (nb == 4) a[1:0] = 2'b00;
      end
      x = $urandom;
      issue(k != 0, rf, wf, f3, a, 5'($urandom_range(0, 31)), x);
    end

    repeat (3) issue(0, 0, 0, 3'd0, 32'h0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit. It consumes the EX/MEM pipeline outputs, issues data-memory requests over a req/gnt/rvalid interface, and aligns store data and load data. It also holds the integrated MEM/WB register that feeds writeback. `stall_mem` freezes the upstream pipeline while a memory access is outstanding.

Parameters:
XLEN, 32, datapath and address width (only 32 supported)
RD_W, 5, destination register index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
valid_mem  input  1  MEM stage holds a valid instruction
alu_out_mem  input  XLEN  ALU result, or effective address for load/store
rd_mem  input  RD_W  destination register
rs2_data_mem  input  XLEN  store data
mem_read_mem  input  1  instruction is a load
mem_write_mem  input  1  instruction is a store
funct3_mem  input  3  RV32I load/store size and sign
dmem_req  output  1  request valid (registered)
dmem_we  output  1  1 = store, 0 = load (registered)
dmem_addr  output  XLEN  word-aligned address, low 2 bits zero (registered)
dmem_wdata  output  XLEN  lane-replicated store data (registered)
dmem_be  output  4  byte enables (registered)
dmem_gnt  input  1  memory accepts the request this cycle
dmem_rvalid  input  1  load data valid
dmem_rdata  input  XLEN  load data, word aligned
stall_mem  output  1  combinational; hold EX/MEM and earlier stages
wb_valid  output  1  registered; writeback slot valid
wb_we  output  1  registered; register-file write enable
wb_rd  output  RD_W  registered destination
wb_data  output  XLEN  registered writeback data
mem_exc  output  1  registered one-cycle pulse; misaligned or illegal access

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous active-high.
- Reset values: state IDLE; every registered output is 0.
- Reset mid-operation: state returns to IDLE, `dmem_req` drops, and any outstanding response is discarded. `dmem_rvalid` in IDLE is ignored.
- States: IDLE, REQ, WAIT_R.
- Memory op (mop): `valid_mem & (mem_read_mem | mem_write_mem)`. If both read and write are set, the access is treated as a load.
- Illegal access, any one of:
  - funct3 not in {000,001,010,100,101} for loads;
  - funct3 not in {000,001,010} for stores;
  - halfword access with `addr[0]=1`;
  - word access with `addr[1:0]!=0`.
- Illegal access handling: no request is issued. Next edge: `wb_valid=1`, `wb_we=0`, `mem_exc=1`. No stall.
- Non-mop valid instruction, 1-cycle latency: next edge `wb_valid=1`, `wb_data=alu_out_mem`, `wb_rd=rd_mem`, `wb_we=(rd_mem!=0)`.
- No valid instruction: next edge `wb_valid=0`, `wb_we=0`.
- IDLE with a legal mop:
  - Registers `dmem_req=1`, `dmem_we`, `dmem_addr={alu_out_mem[31:2],2'b00}`, `dmem_be`, `dmem_wdata`; go to REQ.
  - `wb_valid=0` this edge.
- REQ:
  - `dmem_req` and all dmem fields are held stable until `dmem_gnt` is sampled high.
  - On gnt, `dmem_req` clears at the same edge.
  - Store: go to IDLE and write `wb_valid=1`, `wb_we=0`.
  - Load: go to WAIT_R.
- WAIT_R: on `dmem_rvalid`, write the extended load data to `wb_data`, `wb_we=(rd!=0)`, `wb_valid=1`; go to IDLE.
- `stall_mem` is high when:
  - state is IDLE and a legal mop is present; or
  - state is REQ, except a store with `dmem_gnt` that cycle; or
  - state is WAIT_R without `dmem_rvalid`.
- Upstream holds all `*_mem` inputs stable while `stall_mem=1`. The unit latches the op at issue and does not re-sample inputs.
- Store lanes, with `o=addr[1:0]`:
  - SB: `be=4'b0001<<o`, wdata = byte replicated x4.
  - SH: `be=4'b0011<<o`, wdata = halfword replicated x2.
  - SW: `be=4'b1111`.
- Load extract: select the byte or halfword at `o` from `dmem_rdata`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Ignored inputs: `dmem_gnt` while `dmem_req=0`; `dmem_rvalid` outside WAIT_R.
- `mem_exc` clears on the edge after it is set.

Test Plan:
- Reset while in WAIT_R, then `dmem_rvalid=1` with rdata=0xDEADBEEF the following cycle -> all outputs 0, state IDLE, `wb_valid` stays 0.
- ALU op with `alu_out_mem=0x00001234`, `rd_mem=5` -> next cycle `wb_valid=1`, `wb_we=1`, `wb_rd=5`, `wb_data=0x00001234`, `stall_mem=0`. Same with `rd_mem=0` -> `wb_we=0`.
- SB at addr 0x103, rs2=0x000000A5, gnt delayed 3 cycles -> `dmem_addr=0x100`, `be=4'b1000`, `wdata=0xA5A5A5A5`, req held 4 cycles, `stall_mem` low in the gnt cycle, then `wb_valid=1`, `wb_we=0`.
- LB at 0x102 with rdata=0x12F34567, rvalid 2 cycles after gnt -> `wb_data=0xFFFFFFF3`. LBU at 0x102 -> 0x000000F3. LH at 0x102 -> 0x000012F3.
- LW at 0x101 -> no `dmem_req`, next cycle `mem_exc=1`, `wb_valid=1`, `wb_we=0`, stall never asserted. `mem_exc` is 0 the following cycle.
- Back-to-back LW 0x200 then SW 0x204, `gnt` tied high, rvalid 1 cycle after gnt -> two requests in order, load `wb_valid` before the store's, and `stall_mem` deasserts exactly in the rvalid and gnt cycles respectively.
